tx: RTL and testbench
=====================

// Module: tx
// PURPOSE
//  Output-port transmitter of a router. Arbitrates among PORTS rx buffers requesting this port,
//  reads the winner's FLIT_COUNT-flit packet through the shared buf_addr/buf_data buffer interface,
//  and serialises it onto the outgoing link with a 2-phase (toggle) req/ack handshake.
//  Directly downstream of the rx stage; its channel output feeds the next router's rx.
// PARAMETERS
//  ID         0     instance number used in trace messages
//  MOD_NAME   "TX"  instance name used in trace messages
//  SIZE       8     flit width (bits)
//  BUFF_BITS  3     buffer address bits; FLIT_COUNT = 2**BUFF_BITS flits per packet
//  PORTS      5     number of requesting rx buffers
//  PORT_BITS  3     width of the internal winner index; must satisfy 2**PORT_BITS >= PORTS
// PORTS
//  clk       in   1             clock
//  reset     in   1             asynchronous, active-high reset
//  sw_req    in   PORTS         per-rx level request for this output port
//  sw_gnt    out  PORTS         one-hot grant; held for the whole packet
//  buf_addr  out  BUFF_BITS     flit address broadcast to every rx buffer
//  buf_data  in   PORTS*SIZE    flattened rx buffer read data; port p occupies [p*SIZE +: SIZE]
//  ch_req    out  1             link request; toggles once per flit
//  ch_flit   out  SIZE          link data; stable from a ch_req toggle until the matching ack
//  ch_ack    in   1             link acknowledge; toggles once per accepted flit
// BEHAVIOUR
//  Reset state: sw_gnt=0, buf_addr=0, ch_req=0, ch_flit=0, ch_ack_q=0, rr_ptr=0, state=IDLE.
//  Reset taken mid-packet aborts the packet; no partial-state recovery.
//  ack_evt = ch_ack ^ ch_ack_q; ch_ack_q <= ch_ack every cycle.
//  FSM (registered outputs):
//   IDLE    if |sw_req: round-robin winner w (search starts at rr_ptr, wraps mod PORTS);
//           sw_gnt<=1<<w, sel<=w, buf_addr<=0, rr_ptr<=(w+1)%PORTS, ->LOAD. Otherwise stay.
//   LOAD    ch_flit<=buf_data[sel*SIZE +: SIZE] at current buf_addr, ch_req<=~ch_req, ->WAIT.
//   WAIT    hold outputs until ack_evt. Then:
//           if buf_addr==FLIT_COUNT-1: sw_gnt<=0, ->GAP; else buf_addr<=buf_addr+1, ->LOAD.
//   GAP     one cycle with sw_gnt=0, so the rx sees grant low; ->IDLE.
//           No re-arbitration in this cycle, even if sw_req is already asserted.
//  Latency: sw_req high in IDLE -> sw_gnt high after 1 edge; first ch_req toggle after 2 edges.
//   Each flit costs 2 cycles plus the link ack delay.
//  Requests: sw_req may drop once sw_gnt is seen; requests are sampled only in IDLE.
//   A request that drops while granted does not abort the packet.
//  Simultaneous requests: the lowest index at or after rr_ptr wins; the others wait.
//   No port is granted twice in a row while another port is requesting.
//  ack_evt outside WAIT is ignored (see CONFIGURATION).
//  buf_addr wraps never: the packet always ends at FLIT_COUNT-1.
//  sel is never used outside a grant.
// CONFIGURATION
//  TX_PROTO_CHK_EN defined: adds output port proto_err (1 bit, reset 0).
//   proto_err is sticky-set when ack_evt occurs in IDLE, LOAD or GAP; cleared only by reset.
//   Trace $display messages are emitted on grant, each flit sent, and packet done.
//  TX_PROTO_CHK_EN undefined: no proto_err port, no trace output; datapath is identical.
// STRUCTURE
//  Shared include noc_defs.v holds the TX state encodings (IDLE, LOAD, WAIT, GAP as 2-bit
//   localparams), the FLIT_COUNT derivation and the head-flit bit position SIZE-1.
//  Sub-module rr_arbiter (PORTS, PORT_BITS) provides the combinational round-robin pick:
//   inputs req, ptr; outputs any, idx, onehot.
//  tx instantiates rr_arbiter plus its FSM, datapath mux and ack edge detector.
// TESTING
//  1 Single packet: sw_req=5'b00100, buffer 2 holds 0x80..0x87, bench acks each toggle after
//    3 cycles -> sw_gnt=5'b00100; 8 ch_req toggles carrying 0x80..0x87 in order;
//    sw_gnt drops after the 8th ack; one GAP cycle.
//  2 Round-robin: sw_req=5'b10011 held constant for 3 packets -> grants in order
//    port 0, port 1, port 4; rr_ptr ends at 0.
//  3 Slow link: ack delayed 20 cycles -> ch_flit and ch_req stable throughout WAIT;
//    buf_addr advances only after ack_evt.
//  4 Reset after flit 3 acked -> all outputs return to 0 asynchronously; the next request is
//    granted port-0-first and starts at buf_addr=0.
//  5 TX_PROTO_CHK_EN: toggle ch_ack while in IDLE -> proto_err=1 and stays set;
//    the next packet still transfers correctly.
//  6 Back-to-back: port 1 re-asserts sw_req during GAP -> no grant in GAP; granted on the
//    following IDLE cycle.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the router output-port transmitter: FSM encoding and
// packet geometry helpers.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } tx_state_e;

  function automatic int unsigned flit_count(input int unsigned buff_bits);
    return 32'd1 << buff_bits;
  endfunction

  // Bit position of the head-flit marker inside a flit.
  function automatic int unsigned head_bit(input int unsigned size);
    return size - 32'd1;
  endfunction

endpackage

// File: rtl/tx_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr,
// wrapping modulo PORTS.
module rr_arbiter #(
  parameter int unsigned PORTS     = 5,
  parameter int unsigned PORT_BITS = 3
) (
  input  logic [PORTS-1:0]     req,
  input  logic [PORT_BITS-1:0] ptr,
  output logic                 any,
  output logic [PORT_BITS-1:0] idx,
  output logic [PORTS-1:0]     onehot
);

  logic [PORTS-1:0] rot;
  int unsigned      off;
  int unsigned      sum;

  // Rotate so that bit 0 is the port at ptr, then find the first set bit.
  always_comb begin
    rot = PORTS'({req, req} >> ptr);
    any = 1'b0;
    off = 32'd0;
    for (int k = int'(PORTS) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        off = 32'(k);
      end
    end
    sum = 32'(ptr) + off;
    if (sum >= PORTS) sum = sum - PORTS;
    idx    = PORT_BITS'(sum);
    onehot = any ? (PORTS'(1) << idx) : '0;
  end

endmodule

// File: rtl/tx.sv
// Router output-port transmitter: round-robin grant, packet read from the rx
// buffers, 2-phase req/ack link serialiser. Optional checker: TX_PROTO_CHK_EN.
module tx
  import tx_pkg::*;
#(
  parameter int          ID        = 0,
  parameter              MOD_NAME  = "TX",
  parameter int unsigned SIZE      = 8,
  parameter int unsigned BUFF_BITS = 3,
  parameter int unsigned PORTS     = 5,
  parameter int unsigned PORT_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PORTS-1:0]      sw_req,
  output logic [PORTS-1:0]      sw_gnt,
  output logic [BUFF_BITS-1:0]  buf_addr,
  input  logic [PORTS*SIZE-1:0] buf_data,
  output logic                  ch_req,
  output logic [SIZE-1:0]       ch_flit,
  input  logic                  ch_ack
`ifdef TX_PROTO_CHK_EN
  ,
  output logic                  proto_err
`endif
);

  localparam int unsigned FLIT_COUNT = flit_count(BUFF_BITS);
  localparam logic [BUFF_BITS-1:0] LAST_ADDR = BUFF_BITS'(FLIT_COUNT - 1);
  localparam logic [PORT_BITS-1:0] LAST_PORT = PORT_BITS'(PORTS - 1);

  if (PORTS > (32'd1 << PORT_BITS)) begin : g_bad_port_bits
    $error("%s%0d: PORT_BITS too narrow for PORTS", MOD_NAME, ID);
  end

  tx_state_e            state_q, state_n;
  logic [PORTS-1:0]     gnt_q, gnt_n;
  logic [PORT_BITS-1:0] sel_q, sel_n;
  logic [BUFF_BITS-1:0] addr_q, addr_n;
  logic [PORT_BITS-1:0] ptr_q, ptr_n;
  logic                 req_q, req_n;
  logic [SIZE-1:0]      flit_q, flit_n;
  logic                 ack_q;
  logic                 ack_evt;
  logic [SIZE-1:0]      lane;

  logic                 arb_any;
  logic [PORT_BITS-1:0] arb_idx;
  logic [PORTS-1:0]     arb_onehot;

  rr_arbiter #(
    .PORTS     (PORTS),
    .PORT_BITS (PORT_BITS)
  ) u_arb (
    .req    (sw_req),
    .ptr    (ptr_q),
    .any    (arb_any),
    .idx    (arb_idx),
    .onehot (arb_onehot)
  );

  assign ack_evt = ch_ack ^ ack_q;

  // Read-data mux for the granted rx buffer.
  always_comb begin
    lane = '0;
    for (int p = 0; p < int'(PORTS); p++) begin
      if (sel_q == PORT_BITS'(p)) lane = buf_data[p*SIZE +: SIZE];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      ptr_q   <= '0;
      req_q   <= 1'b0;
      flit_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      sel_q   <= sel_n;
      addr_q  <= addr_n;
      ptr_q   <= ptr_n;
      req_q   <= req_n;
      flit_q  <= flit_n;
      ack_q   <= ch_ack;
    end
  end

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    sel_n   = sel_q;
    addr_n  = addr_q;
    ptr_n   = ptr_q;
    req_n   = req_q;
    flit_n  = flit_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_n   = arb_onehot;
          sel_n   = arb_idx;
          addr_n  = '0;
          ptr_n   = (arb_idx == LAST_PORT) ? '0 : arb_idx + PORT_BITS'(1);
          state_n = LOAD;
        end
      end
      LOAD: begin
        flit_n  = lane;
        req_n   = ~req_q;
        state_n = WAIT;
      end
      WAIT: begin
        if (ack_evt) begin
          if (addr_q == LAST_ADDR) begin
            gnt_n   = '0;
            state_n = GAP;
          end else begin
            addr_n  = addr_q + BUFF_BITS'(1);
            state_n = LOAD;
          end
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign sw_gnt   = gnt_q;
  assign buf_addr = addr_q;
  assign ch_req   = req_q;
  assign ch_flit  = flit_q;

`ifdef TX_PROTO_CHK_EN
  logic perr_q;

  // An ack toggle is only legal while a flit is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) perr_q <= 1'b0;
    else if (ack_evt && state_q != WAIT) perr_q <= 1'b1;
  end

  assign proto_err = perr_q;

  always @(posedge clk) begin
    if (!reset) begin
      if (state_q == IDLE && arb_any)
        $display("%s%0d: grant port %0d", MOD_NAME, ID, arb_idx);
      if (state_q == LOAD)
        $display("%s%0d: flit addr %0d data %h", MOD_NAME, ID, addr_q, lane);
      if (state_q == WAIT && ack_evt && addr_q == LAST_ADDR)
        $display("%s%0d: packet done port %0d", MOD_NAME, ID, sel_q);
    end
  end
`endif

endmodule

// File: tb/tb_tx.sv
// Directed self-checking bench for tx: rx buffer model plus a toggle-ack link
// responder with a programmable ack delay.
module tb_tx;

  localparam int unsigned SIZE      = 8;
  localparam int unsigned BUFF_BITS = 3;
  localparam int unsigned PORTS     = 5;
  localparam int unsigned PORT_BITS = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [PORTS-1:0]      sw_req = '0;
  logic [PORTS-1:0]      sw_gnt;
  logic [BUFF_BITS-1:0]  buf_addr;
  logic [PORTS*SIZE-1:0] buf_data;
  logic                  ch_req;
  logic [SIZE-1:0]       ch_flit;
  logic                  ch_ack = 1'b0;
`ifdef TX_PROTO_CHK_EN
  logic                  proto_err;
`endif

  int checks = 0;
  int failures = 0;

  int ack_delay = 3;
  int kick_cnt = 0;
  int kick_seen = 0;
  int unstable = 0;
  logic [SIZE-1:0]      got[$];
  logic [PORTS-1:0]     gnts[$];
  logic                 last_req = 1'b0;
  logic                 pend = 1'b0;
  int                   cnt = 0;
  logic [SIZE-1:0]      held_flit = '0;
  logic [BUFF_BITS-1:0] held_addr = '0;
  logic [PORTS-1:0]     prev_gnt = '0;

  tx dut (
    .clk      (clk),
    .reset    (reset),
    .sw_req   (sw_req),
    .sw_gnt   (sw_gnt),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .ch_req   (ch_req),
    .ch_flit  (ch_flit),
    .ch_ack   (ch_ack)
`ifdef TX_PROTO_CHK_EN
    ,
    .proto_err(proto_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [SIZE-1:0] base_of(input int p);
    case (p)
      0:       return 8'h10;
      1:       return 8'h40;
      2:       return 8'h80;
      3:       return 8'hC0;
      default: return 8'hE0;
    endcase
  endfunction

  // rx buffer p holds base_of(p) + address.
  always_comb begin
    buf_data = '0;
    for (int p = 0; p < int'(PORTS); p++)
      buf_data[p*SIZE +: SIZE] = base_of(p) + SIZE'(buf_addr);
  end

  // Link responder and grant/flit logger.
  always @(negedge clk) begin
    if (reset) begin
      ch_ack    = 1'b0;
      last_req  = 1'b0;
      pend      = 1'b0;
      cnt       = 0;
      prev_gnt  = '0;
      kick_seen = kick_cnt;
    end else begin
      if (kick_cnt != kick_seen) begin
        kick_seen = kick_seen + 1;
        ch_ack = ~ch_ack;
      end
      if (sw_gnt != '0 && prev_gnt == '0) gnts.push_back(sw_gnt);
      prev_gnt = sw_gnt;
      if (ch_req != last_req) begin
        last_req  = ch_req;
        pend      = 1'b1;
        cnt       = ack_delay;
        held_flit = ch_flit;
        held_addr = buf_addr;
        got.push_back(ch_flit);
      end else if (pend) begin
        if (ch_flit != held_flit || buf_addr != held_addr) unstable = unstable + 1;
        if (cnt > 1) cnt = cnt - 1;
        else begin
          ch_ack = ~ch_ack;
          pend   = 1'b0;
        end
      end
    end
  end

  task automatic wait_done(input int total, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk); #1;
      if (got.size() >= total && sw_gnt == '0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk); #1;
      if (sw_gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (sw_gnt !== '0) begin failures++; $display("FAIL reset_gnt: got %b expected 0", sw_gnt); end
    checks++; if (buf_addr !== '0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", buf_addr); end
    checks++; if (ch_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", ch_req); end
    checks++; if (ch_flit !== '0) begin failures++; $display("FAIL reset_flit: got %h expected 00", ch_flit); end
    #1 reset = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_single();
    int base;
    logic r0;
    logic [SIZE-1:0] act;
    bit ok;
    base = got.size();
    ack_delay = 3;
    r0 = ch_req;
    sw_req = 5'b00100;
    @(negedge clk); #1;
    checks++; if (sw_gnt !== 5'b00100) begin failures++; $display("FAIL single_gnt: got %b expected 00100", sw_gnt); end
    checks++; if (ch_req !== r0) begin failures++; $display("FAIL single_req_early: got %b expected %b", ch_req, r0); end
    sw_req = '0;
    @(negedge clk); #1;
    checks++; if (ch_req !== ~r0) begin failures++; $display("FAIL single_req_toggle: got %b expected %b", ch_req, ~r0); end
    checks++; if (ch_flit !== 8'h80) begin failures++; $display("FAIL single_first_flit: got %h expected 80", ch_flit); end
    wait_done(base + 8, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout: got incomplete expected done"); end
    checks++; if (got.size() !== base + 8) begin failures++; $display("FAIL single_count: got %0d expected %0d", got.size() - base, 8); end
    for (int i = 0; i < 8; i++) begin
      act = (got.size() > base + i) ? got[base + i] : 'x;
      checks++;
      if (act !== 8'h80 + SIZE'(i)) begin
        failures++; $display("FAIL single_flit%0d: got %h expected %h", i, act, 8'h80 + SIZE'(i));
      end
    end
  endtask

  task automatic test_round_robin();
    int base, gbase;
    logic [PORTS-1:0] exp_g [4];
    logic [PORTS-1:0] act;
    bit ok;
    exp_g[0] = 5'b00001; exp_g[1] = 5'b00010; exp_g[2] = 5'b10000; exp_g[3] = 5'b00001;
    do_reset();
    base = got.size();
    gbase = gnts.size();
    sw_req = 5'b10011;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (gnts.size() >= gbase + 3) begin ok = 1'b1; break; end
    end
    sw_req = '0;
    checks++; if (!ok) begin failures++; $display("FAIL rr_grant_timeout: got %0d grants expected 3", gnts.size() - gbase); end
    wait_done(base + 24, 300, ok);
    sw_req = 5'b11111;
    wait_grant(20, ok);
    sw_req = '0;
    wait_done(base + 32, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_timeout: got incomplete expected done"); end
    for (int i = 0; i < 4; i++) begin
      act = (gnts.size() > gbase + i) ? gnts[gbase + i] : 'x;
      checks++;
      if (act !== exp_g[i]) begin
        failures++; $display("FAIL rr_grant%0d: got %b expected %b", i, act, exp_g[i]);
      end
    end
    checks++;
    if (got.size() < base + 24 || got[base + 8] !== 8'h40 || got[base + 23] !== 8'hE7) begin
      failures++; $display("FAIL rr_data: got size %0d expected port1/port4 data 40..E7", got.size() - base);
    end
  endtask

  task automatic test_slow_link();
    int base, u0;
    bit ok;
    base = got.size();
    u0 = unstable;
    ack_delay = 20;
    sw_req = 5'b00100;
    wait_grant(20, ok);
    sw_req = '0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (buf_addr !== 3'd0 || ch_flit !== 8'h80) begin
      failures++; $display("FAIL slow_hold: got addr %0d flit %h expected addr 0 flit 80", buf_addr, ch_flit);
    end
    wait_done(base + 8, 600, ok);
    checks++; if (!ok) begin failures++; $display("FAIL slow_timeout: got incomplete expected done"); end
    checks++; if (unstable !== u0) begin failures++; $display("FAIL slow_stable: got %0d changes expected 0", unstable - u0); end
    checks++; if (got.size() < base + 8 || got[base + 7] !== 8'h87) begin
      failures++; $display("FAIL slow_last_flit: got size %0d expected last flit 87", got.size() - base);
    end
    ack_delay = 3;
  endtask

  task automatic test_reset_mid_packet();
    int base;
    bit ok;
    sw_req = 5'b01000;
    wait_grant(20, ok);
    sw_req = '0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (buf_addr == 3'd4) begin ok = 1'b1; break; end
    end
    @(negedge clk); #1;
    checks++; if (!ok || ch_flit !== 8'hC4) begin
      failures++; $display("FAIL mid_flit4: got %h expected C4", ch_flit);
    end
    reset = 1'b1;
    #1;
    checks++; if (sw_gnt !== '0) begin failures++; $display("FAIL mid_rst_gnt: got %b expected 0", sw_gnt); end
    checks++; if (buf_addr !== '0) begin failures++; $display("FAIL mid_rst_addr: got %0d expected 0", buf_addr); end
    checks++; if (ch_req !== 1'b0) begin failures++; $display("FAIL mid_rst_req: got %b expected 0", ch_req); end
    checks++; if (ch_flit !== '0) begin failures++; $display("FAIL mid_rst_flit: got %h expected 00", ch_flit); end
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk); #1;
    base = got.size();
    sw_req = 5'b11111;
    @(negedge clk); #1;
    checks++; if (sw_gnt !== 5'b00001) begin failures++; $display("FAIL mid_regrant: got %b expected 00001", sw_gnt); end
    sw_req = '0;
    @(negedge clk); #1;
    checks++; if (buf_addr !== '0 || ch_flit !== 8'h10) begin
      failures++; $display("FAIL mid_restart: got addr %0d flit %h expected addr 0 flit 10", buf_addr, ch_flit);
    end
    wait_done(base + 8, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_timeout: got incomplete expected done"); end
  endtask

  task automatic test_proto();
    int base;
    logic r0;
    bit ok;
    r0 = ch_req;
`ifdef TX_PROTO_CHK_EN
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL proto_clear: got %b expected 0", proto_err); end
`endif
    kick_cnt = kick_cnt + 1;
    repeat (3) @(negedge clk);
    #1;
`ifdef TX_PROTO_CHK_EN
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_set: got %b expected 1", proto_err); end
`else
    checks++; if (sw_gnt !== '0 || ch_req !== r0) begin
      failures++; $display("FAIL proto_ignored: got gnt %b req %b expected 0 %b", sw_gnt, ch_req, r0);
    end
`endif
    base = got.size();
    sw_req = 5'b10000;
    wait_grant(20, ok);
    sw_req = '0;
    wait_done(base + 8, 300, ok);
    checks++; if (!ok || got.size() < base + 8 || got[base] !== 8'hE0 || got[base + 7] !== 8'hE7) begin
      failures++; $display("FAIL proto_packet: got size %0d expected flits E0..E7", got.size() - base);
    end
`ifdef TX_PROTO_CHK_EN
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
`endif
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    base = got.size();
    sw_req = 5'b00010;
    wait_grant(20, ok);
    sw_req = '0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (sw_gnt == '0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: got gnt %b expected drop", sw_gnt); end
    sw_req = 5'b00010;
    @(negedge clk); #1;
    checks++; if (sw_gnt !== '0) begin failures++; $display("FAIL b2b_gap_grant: got %b expected 0", sw_gnt); end
    @(negedge clk); #1;
    checks++; if (sw_gnt !== 5'b00010) begin failures++; $display("FAIL b2b_regrant: got %b expected 00010", sw_gnt); end
    sw_req = '0;
    wait_done(base + 16, 300, ok);
    checks++; if (!ok || got.size() < base + 16 || got[base + 8] !== 8'h40) begin
      failures++; $display("FAIL b2b_data: got size %0d expected second packet from 40", got.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_slow_link();
    test_reset_mid_packet();
    test_proto();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
